dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shared data-memory port arbiter for the multi-core system.
- Lets N_CORES SM cores share one single-port synchronous DataMemory.
- Round-robin grant: at most one access per cycle.
- Read data returns to the granting core after a fixed memory latency, tagged by a pipelined grant-ID shift register.

Parameters:
- N_CORES, 4, number of SM cores sharing the memory (2..16).
- ADDR_W, 8, data memory address width (matches DATAMEM_ADDR_WIDTH).
- DATA_W, 32, data word width (matches DATA_WORD_LENGTH).
- MEM_LAT, 1, cycles from address presented on mem_addr to valid mem_rdata (1..4).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  N_CORES  per-core access request; held until granted.
- core_we  in  N_CORES  per-core write enable; 1 = write, 0 = read.
- core_addr  in  N_CORES*ADDR_W  flat per-core addresses; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  N_CORES*DATA_W  flat per-core write data.
- core_gnt  out  N_CORES  one-hot grant; request accepted this cycle.
- core_rvalid  out  N_CORES  one-hot read-data-valid strobe.
- core_rdata  out  DATA_W  read data, broadcast to all cores; qualified by core_rvalid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- State:
  - rr_ptr: log2(N_CORES) bits, reset 0.
  - Tag pipeline: MEM_LAT stages of {valid, id}, reset all valid=0.
- Reset:
  - core_gnt=0, core_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Asserting reset mid-operation flushes the tag pipeline; no rvalid is issued for reads in flight.
- Arbitration (combinational from registered rr_ptr and core_req):
  - Grant the first requesting core at index rr_ptr, rr_ptr+1, … mod N_CORES.
  - core_gnt is one-hot or zero.
  - No request: core_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, rr_ptr unchanged.
- Pointer update: on a grant to core g, rr_ptr <= (g+1) mod N_CORES, with wrap from N_CORES-1 to 0.
- Memory drive:
  - mem_we/mem_addr/mem_wdata come combinationally from the granted core's inputs in the grant cycle.
  - mem_we = granted core's core_we.
- Handshake:
  - A core keeps core_req, core_we, core_addr, core_wdata stable until it sees core_gnt high.
  - The access completes in the grant cycle.
  - A core may re-request in the cycle after its grant.
  - Dropping core_req before grant is legal; that request is simply never serviced.
- Read return:
  - A read granted at cycle t enters the tag pipeline stage 0 with {1, g}.
  - The tag shifts one stage per cycle.
  - At cycle t+MEM_LAT, core_rvalid[g]=1 (one cycle only) and core_rdata=mem_rdata (combinational pass-through).
- Writes never generate rvalid.
- core_rdata is don't-care when no rvalid; drive mem_rdata unconditionally.
- Throughput:
  - One access per cycle sustained.
  - Reads issued on consecutive cycles return on consecutive cycles in issue order.
  - Simultaneous grant of a new read and rvalid of an older read is normal.
- Fairness: with all cores continuously requesting, each core is granted exactly once every N_CORES cycles.
- Width rules: id width = max(1, $clog2(N_CORES)); no arithmetic beyond the modulo pointer increment.

Test Plan:
- Single read, MEM_LAT=1:
  - Stimulus: core 2 req, we=0, addr=0x10; memory holds 0xDEADBEEF.
  - Response: core_gnt=4'b0100 in the same cycle; mem_addr=0x10; next cycle core_rvalid=4'b0100 and core_rdata=0xDEADBEEF.
- Round-robin, all contend:
  - Stimulus: all 4 cores hold req from reset.
  - Response: grants 0,1,2,3,0,1 on consecutive cycles; rr_ptr wraps 3→0.
- Pointer skip:
  - Stimulus: rr_ptr=1 after granting core 0; only cores 0 and 3 request.
  - Response: core 3 granted first, then core 0.
- Write then read-back:
  - Stimulus: core 1 writes 0x12345678 to addr 0x20, then reads 0x20.
  - Response: mem_we=1 only in the write grant cycle; no rvalid for the write; read returns 0x12345678 with core_rvalid[1].
- Back-to-back reads, MEM_LAT=2:
  - Stimulus: cores 0 and 1 read addrs 0x01 and 0x02 in cycles t and t+1.
  - Response: core_rvalid[0] at t+2 and core_rvalid[1] at t+3, each with correct data.
- Reset mid-flight, MEM_LAT=3:
  - Stimulus: assert reset one cycle after a read grant.
  - Response: all outputs 0 immediately (asynchronous); no core_rvalid after reset release; rr_ptr=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets N_CORES cores share one single-port synchronous data
// memory. A round-robin arbiter grants at most one access per cycle and
// drives the memory combinationally in the grant cycle. A read's
// {valid, core id} tag is carried through a MEM_LAT-deep shift register, so
// the read data is steered to the requesting core when it comes back.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   core_req/we         per-core request and write enable (one bit per core)
//   core_addr/wdata     flat per-core address and write data, core i at [i*W +: W]
//   core_gnt            one-hot grant, combinational in the accept cycle
//   core_rvalid         one-hot read-data strobe, MEM_LAT cycles after a read grant
//   core_rdata          read data broadcast to all cores (mem_rdata pass-through)
//   mem_we/addr/wdata   memory request, taken from the granted core
//   mem_rdata           memory read data
module dmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CORES-1:0]        core_req,
  input  logic [N_CORES-1:0]        core_we,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_gnt,
  output logic [N_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]         core_rdata,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int ID_W = (N_CORES < 2) ? 1 : $clog2(N_CORES);

  logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [MEM_LAT-1:0]           tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0][ID_W-1:0] tag_id_q, tag_id_d;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;

  // Search starting at rr_ptr and wrapping; the first requester wins. The
  // grant is suppressed while reset is asserted so that the memory-side outputs
  // drop to zero immediately, not only on the next edge.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      int unsigned idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!gnt_vld && core_req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    if (reset) gnt_vld = 1'b0;
  end

  always_comb begin
    core_gnt  = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_vld) begin
      core_gnt[gnt_id] = 1'b1;
      mem_we           = core_we[gnt_id];
      mem_addr         = core_addr[gnt_id*ADDR_W +: ADDR_W];
      mem_wdata        = core_wdata[gnt_id*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_id == ID_W'(N_CORES - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Stage 0 captures a granted read; each later stage copies its predecessor.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = gnt_vld && !core_we[gnt_id];
    tag_id_d[0]  = gnt_id;
    for (int unsigned s = 1; s < MEM_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  always_comb begin
    core_rvalid = '0;
    if (tag_vld_q[MEM_LAT-1]) core_rvalid[tag_id_q[MEM_LAT-1]] = 1'b1;
  end

  assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, we;
  logic [31:0]  addr;
  logic [127:0] wdata;

  logic [3:0]  gnt1, gnt2, gnt3, rv1, rv2, rv3;
  logic [31:0] rdata1, rdata2, rdata3, mwdata1, mwdata2, mwdata3;
  logic [31:0] mrd1, mrd2, mrd3;
  logic [7:0]  maddr1, maddr2, maddr3;
  logic        mwe1, mwe2, mwe3;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [256];
  logic [31:0] p2, p3a, p3b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.N_CORES(4), .ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .core_req(req), .core_we(we), .core_addr(addr),
    .core_wdata(wdata), .core_gnt(gnt1), .core_rvalid(rv1), .core_rdata(rdata1),
    .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_rdata(mrd1));

  dmem_arbiter #(.N_CORES(4), .ADDR_W(8), .DATA_W(32), .MEM_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .core_req(req), .core_we(we), .core_addr(addr),
    .core_wdata(wdata), .core_gnt(gnt2), .core_rvalid(rv2), .core_rdata(rdata2),
    .mem_we(mwe2), .mem_addr(maddr2), .mem_wdata(mwdata2), .mem_rdata(mrd2));

  dmem_arbiter #(.N_CORES(4), .ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .core_req(req), .core_we(we), .core_addr(addr),
    .core_wdata(wdata), .core_gnt(gnt3), .core_rvalid(rv3), .core_rdata(rdata3),
    .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_rdata(mrd3));

  // Shared storage; all three instances see identical requests, so writes
  // follow the MEM_LAT=1 instance. Each instance gets its own read latency.
  always @(posedge clk) begin
    if (pre_we)    mem[pre_addr] <= pre_data;
    else if (mwe1) mem[maddr1]   <= mwdata1;
  end

  always @(posedge clk) begin
    mrd1 <= mem[maddr1];
    p2   <= mem[maddr2];
    mrd2 <= p2;
    p3a  <= mem[maddr3];
    p3b  <= p3a;
    mrd3 <= p3b;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    next_cycle();
    pre_we = 1'b0;
  endtask

  task automatic set_core(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
    we[i]             = w;
    addr[i*8 +: 8]    = a;
    wdata[i*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g [6];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h01, 32'hA1A1A1A1);
    preload(8'h02, 32'hB2B2B2B2);

    // Reset: outputs held at zero even with requests pending
    req = 4'hF;
    @(negedge clk);
    check_eq("rst_gnt1", gnt1, 0);
    check_eq("rst_gnt3", gnt3, 0);
    check_eq("rst_mwe", mwe1, 0);
    check_eq("rst_maddr", maddr1, 0);
    check_eq("rst_mwdata", mwdata1, 0);
    check_eq("rst_rv", rv1 | rv2 | rv3, 0);
    next_cycle();
    reset = 1'b0; req = '0;

    // Single read by core 2
    set_core(2, 1'b0, 8'h10, 32'h0);
    req = 4'b0100;
    @(negedge clk);
    check_eq("rd_gnt", gnt1, 4'b0100);
    check_eq("rd_maddr", maddr1, 8'h10);
    check_eq("rd_mwe", mwe1, 0);
    next_cycle(); req = '0;
    @(negedge clk);
    check_eq("rd_rv1", rv1, 4'b0100);
    check_eq("rd_rdata1", rdata1, 32'hDEADBEEF);
    check_eq("rd_rv2_early", rv2, 0);
    next_cycle();
    @(negedge clk);
    check_eq("rd_rv1_once", rv1, 0);
    check_eq("rd_rv2", rv2, 4'b0100);
    check_eq("rd_rdata2", rdata2, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check_eq("rd_rv3", rv3, 4'b0100);
    check_eq("rd_rdata3", rdata3, 32'hDEADBEEF);
    next_cycle();

    // Round-robin, all cores contend from reset
    pulse_reset();
    for (int i = 0; i < 4; i++) set_core(i, 1'b0, 8'(8'h30 + i), 32'h0);
    req = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("rr_gnt%0d", i), gnt1, exp_g[i]);
      if (i > 0) check_eq($sformatf("rr_rv%0d", i), rv1, exp_g[i-1]);
      next_cycle();
    end
    req = '0;

    // Pointer skip: rr_ptr=1, cores 0 and 3 request
    pulse_reset();
    req = 4'b0001;
    @(negedge clk);
    check_eq("skip_g0", gnt1, 4'b0001);
    next_cycle(); req = 4'b1001;
    @(negedge clk);
    check_eq("skip_g3", gnt1, 4'b1000);
    next_cycle(); req = 4'b0001;
    @(negedge clk);
    check_eq("skip_g0b", gnt1, 4'b0001);
    next_cycle(); req = '0;

    // Write then read-back by core 1
    set_core(1, 1'b1, 8'h20, 32'h12345678);
    req = 4'b0010;
    @(negedge clk);
    check_eq("wr_gnt", gnt1, 4'b0010);
    check_eq("wr_mwe", mwe1, 1);
    check_eq("wr_maddr", maddr1, 8'h20);
    check_eq("wr_mwdata", mwdata1, 32'h12345678);
    next_cycle();
    set_core(1, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    check_eq("rb_gnt", gnt1, 4'b0010);
    check_eq("rb_mwe", mwe1, 0);
    check_eq("wr_no_rv", rv1, 0);
    next_cycle(); req = '0;
    @(negedge clk);
    check_eq("rb_rv", rv1, 4'b0010);
    check_eq("rb_rdata", rdata1, 32'h12345678);
    check_eq("idle_gnt", gnt1, 0);
    check_eq("idle_mwe", mwe1, 0);
    check_eq("idle_maddr", maddr1, 0);
    check_eq("idle_mwdata", mwdata1, 0);
    next_cycle();

    // Back-to-back reads, MEM_LAT=2
    set_core(0, 1'b0, 8'h01, 32'h0);
    req = 4'b0001;
    @(negedge clk);
    check_eq("b2b_g0", gnt2, 4'b0001);
    next_cycle();
    set_core(1, 1'b0, 8'h02, 32'h0);
    req = 4'b0010;
    @(negedge clk);
    check_eq("b2b_g1", gnt2, 4'b0010);
    check_eq("b2b_overlap_rv1", rv1, 4'b0001);
    next_cycle(); req = '0;
    @(negedge clk);
    check_eq("b2b_rv_a", rv2, 4'b0001);
    check_eq("b2b_data_a", rdata2, 32'hA1A1A1A1);
    next_cycle();
    @(negedge clk);
    check_eq("b2b_rv_b", rv2, 4'b0010);
    check_eq("b2b_data_b", rdata2, 32'hB2B2B2B2);
    next_cycle();

    // Reset mid-flight, MEM_LAT=3
    set_core(0, 1'b0, 8'h10, 32'h0);
    req = 4'b0001;
    @(negedge clk);
    check_eq("mf_gnt", gnt3, 4'b0001);
    next_cycle();
    reset = 1'b1; req = 4'b0100;
    @(negedge clk);
    check_eq("mf_rst_gnt", gnt3, 0);
    check_eq("mf_rst_mwe", mwe3, 0);
    check_eq("mf_rst_maddr", maddr3, 0);
    check_eq("mf_rst_mwdata", mwdata3, 0);
    check_eq("mf_rst_rv1", rv1, 0);
    check_eq("mf_rst_rv3", rv3, 0);
    next_cycle();
    reset = 1'b0; req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("mf_no_rv3_%0d", i), rv3, 0);
      check_eq($sformatf("mf_no_rv2_%0d", i), rv2, 0);
      next_cycle();
    end
    req = 4'hF;
    @(negedge clk);
    check_eq("mf_ptr0", gnt3, 4'b0001);
    next_cycle(); req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
